peripheral_noc_packetizer: RTL and testbench

Transmit-side producer of the NoC flit stream (flit/last/valid/ready) that NoC buffers and routers consume. It accepts a packet request descriptor (destination, class, payload length) and a stream of payload words. It emits one header flit followed by exactly req_len payload flits, with last asserted on the final flit. It sits between a network adapter or DMA engine and the local router input buffer.

---
 rtl/peripheral_noc_pkg.sv | 39 +++
 rtl/peripheral_noc_packetizer.sv | 105 ++++++++++
 tb/tb_peripheral_noc_packetizer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_noc_pkg.sv
// Shared NoC header layout: field widths/offsets, packetizer state and header builder.
// Header: dest at the top, then class, then source; payload length in the low bits; remaining bits zero.
package peripheral_noc_pkg;

    localparam int HDR_MAX_W   = 128;
    localparam int DEF_FLIT_W  = 32;
    localparam int DEF_DEST_W  = 5;
    localparam int DEF_CLASS_W = 3;
    localparam int DEF_SRC_W   = 5;
    localparam int DEF_LEN_W   = 8;

    localparam int HDR_DEST_LSB  = DEF_FLIT_W - DEF_DEST_W;
    localparam int HDR_CLASS_LSB = HDR_DEST_LSB - DEF_CLASS_W;
    localparam int HDR_SRC_LSB   = HDR_CLASS_LSB - DEF_SRC_W;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } pkt_state_t;

    // Field widths are run-time arguments so any flit geometry up to HDR_MAX_W can share it;
    // callers keep the low fw bits of the result.
    function automatic logic [HDR_MAX_W-1:0] build_header(
        input logic [HDR_MAX_W-1:0] dest,
        input logic [HDR_MAX_W-1:0] cls,
        input logic [HDR_MAX_W-1:0] src,
        input logic [HDR_MAX_W-1:0] len,
        input int fw, input int dw, input int cw, input int sw, input int lw
    );
        logic [HDR_MAX_W-1:0] ones;
        ones = '1;
        build_header = ((dest & (ones >> (HDR_MAX_W - dw))) << (fw - dw))
                     | ((cls  & (ones >> (HDR_MAX_W - cw))) << (fw - dw - cw))
                     | ((src  & (ones >> (HDR_MAX_W - sw))) << (fw - dw - cw - sw))
                     |  (len  & (ones >> (HDR_MAX_W - lw)));
    endfunction

endpackage

// File: rtl/peripheral_noc_packetizer.sv
// Turns a request descriptor plus payload words into a header flit followed by req_len payload flits.
// Latency: one cycle from an accepted request/payload handshake to out_valid; 1 flit/cycle sustained.
// Backpressure: one-entry output register; both ready outputs drop while it is full and stalled.
module peripheral_noc_packetizer
    import peripheral_noc_pkg::*;
#(
    parameter int FLIT_WIDTH  = 32,
    parameter int DEST_WIDTH  = 5,
    parameter int CLASS_WIDTH = 3,
    parameter int SRC_WIDTH   = 5,
    parameter int LEN_WIDTH   = 8,
    parameter int SRC_ID      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DEST_WIDTH-1:0]  req_dest,
    input  logic [CLASS_WIDTH-1:0] req_class,
    input  logic [LEN_WIDTH-1:0]   req_len,
    input  logic [FLIT_WIDTH-1:0]  in_flit,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [FLIT_WIDTH-1:0]  out_flit,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    if (DEST_WIDTH + CLASS_WIDTH + SRC_WIDTH + LEN_WIDTH > FLIT_WIDTH || FLIT_WIDTH >= HDR_MAX_W) begin : g_width_check
        $fatal(1, "peripheral_noc_packetizer: header fields do not fit in FLIT_WIDTH");
    end

    pkt_state_t            state;
    pkt_state_t            state_nxt;
    logic                  adv;
    logic                  hdr_acc;
    logic                  pay_acc;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [HDR_MAX_W-1:0]  hdr_full;
    logic [FLIT_WIDTH-1:0] hdr;
    logic                  unused_hdr_hi;

    assign hdr_full = build_header(HDR_MAX_W'(req_dest), HDR_MAX_W'(req_class),
                                   HDR_MAX_W'(SRC_ID), HDR_MAX_W'(req_len),
                                   FLIT_WIDTH, DEST_WIDTH, CLASS_WIDTH, SRC_WIDTH, LEN_WIDTH);
    assign hdr           = hdr_full[FLIT_WIDTH-1:0];
    assign unused_hdr_hi = ^hdr_full[HDR_MAX_W-1:FLIT_WIDTH];

    assign adv     = ~out_valid | out_ready;
    assign hdr_acc = req_valid & req_ready;
    assign pay_acc = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hdr_acc && req_len != '0) state_nxt = PAYLOAD;
            PAYLOAD: if (pay_acc && remaining == LEN_WIDTH'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready outputs are held low during reset so no handshake is accepted and then dropped.
    always_comb begin
        req_ready = 1'b0;
        in_ready  = 1'b0;
        if (!rst) begin
            req_ready = adv & (state == IDLE);
            in_ready  = adv & (state == PAYLOAD);
        end
    end

    assign busy = (state == PAYLOAD) | out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            out_flit  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (hdr_acc) begin
            remaining <= req_len;
            out_flit  <= hdr;
            out_last  <= (req_len == '0);
            out_valid <= 1'b1;
        end else if (pay_acc) begin
            remaining <= remaining - LEN_WIDTH'(1);
            out_flit  <= in_flit;
            out_last  <= (remaining == LEN_WIDTH'(1));
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peripheral_noc_packetizer.sv
// Directed self-checking bench for peripheral_noc_packetizer (SRC_ID = 9, default widths).
module tb_peripheral_noc_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_dest;
    logic [2:0]  req_class;
    logic [7:0]  req_len;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    peripheral_noc_packetizer #(
        .FLIT_WIDTH(32), .DEST_WIDTH(5), .CLASS_WIDTH(3),
        .SRC_WIDTH(5), .LEN_WIDTH(8), .SRC_ID(9)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_class(req_class), .req_len(req_len),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] q_flit[$];
    logic        q_last[$];
    int          q_cyc[$];
    int          stall_bad = 0;
    int          ready_bad = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_flit;
    logic        prev_last;
    bit          toggle_mode = 1'b0;
    int          tog_idx = 0;

    function automatic logic [31:0] hexp(input logic [4:0] d, input logic [2:0] c, input logic [7:0] l);
        return {d, c, 5'd9, 11'd0, l};
    endfunction

    // Transfer monitor: records every flit the downstream takes, watches stall stability.
    always @(negedge clk) begin
        cyc++;
        if (prev_stall && !rst && (out_flit !== prev_flit || out_last !== prev_last || out_valid !== 1'b1))
            stall_bad++;
        if (!rst && out_valid && !out_ready && (req_ready || in_ready))
            ready_bad++;
        prev_stall = out_valid && !out_ready && !rst;
        prev_flit  = out_flit;
        prev_last  = out_last;
        if (!rst && out_valid && out_ready) begin
            q_flit.push_back(out_flit);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (toggle_mode) begin
                out_ready = (tog_idx % 4 == 0) || (tog_idx % 4 == 3);
                tog_idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic clear_q();
        q_flit.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic send_pkt(input logic [4:0] d, input logic [2:0] c, input logic [7:0] l, input logic [31:0] base);
        int  cnt;
        bit  acc;
        req_valid = 1'b1; req_dest = d; req_class = c; req_len = l;
        cnt = 0; acc = 1'b0;
        while (!acc && cnt < 1000) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1; cnt++;
        end
        req_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL req_accept_timeout got req_ready=0 for %0d cycles, required 1", cnt);
        end
        for (int i = 0; i < int'(l); i++) begin
            in_valid = 1'b1; in_flit = base + 32'(i);
            cnt = 0; acc = 1'b0;
            while (!acc && cnt < 1000) begin
                @(negedge clk); acc = in_ready;
                @(posedge clk); #1; cnt++;
            end
            in_valid = 1'b0;
            if (!acc) begin
                checks++; errors++;
                $display("FAIL payload_accept_timeout word %0d got in_ready=0, required 1", i);
            end
        end
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 2000) begin
            @(negedge clk); cnt++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b, required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; in_valid = 1'b1;
        req_dest = 5'd1; req_class = 3'd1; req_len = 8'd1; in_flit = 32'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b required 0", req_ready); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b required 0", out_last); end
        checks++; if (out_flit !== 32'h0) begin errors++; $display("FAIL rst_out_flit got %h required 0", out_flit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_len0();
        clear_q();
        req_valid = 1'b1; req_dest = 5'd3; req_class = 3'd1; req_len = 8'd0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL len0_req_ready got %b required 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len0_out_valid got %b required 1", out_valid); end
        checks++; if (out_flit !== hexp(5'd3, 3'd1, 8'd0)) begin errors++; $display("FAIL len0_header got %h required %h", out_flit, hexp(5'd3, 3'd1, 8'd0)); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL len0_last got %b required 1", out_last); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL len0_busy got %b required 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len0_in_ready got %b required 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len0_drain got out_valid=%b required 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy_drop got %b required 0", busy); end
    endtask

    task automatic test_len3();
        logic [31:0] exp_f[4];
        logic        exp_l[4];
        exp_f[0] = hexp(5'd7, 3'd2, 8'd3); exp_f[1] = 32'hA; exp_f[2] = 32'hB; exp_f[3] = 32'hC;
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b0; exp_l[3] = 1'b1;
        clear_q();
        in_valid = 1'b1; in_flit = 32'hA;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len3_in_ready_idle got %b required 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        send_pkt(5'd7, 3'd2, 8'd3, 32'hA);
        wait_idle();
        checks++;
        if (q_flit.size() != 4) begin errors++; $display("FAIL len3_count got %0d required 4", q_flit.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_flit[i] !== exp_f[i] || q_last[i] !== exp_l[i] || q_cyc[i] != q_cyc[0] + i) begin
                    errors++;
                    $display("FAIL len3_flit%0d got %h/%b/cyc+%0d required %h/%b/cyc+%0d",
                             i, q_flit[i], q_last[i], q_cyc[i] - q_cyc[0], exp_f[i], exp_l[i], i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_f[4];
        logic        exp_l[4];
        exp_f[0] = hexp(5'd7, 3'd2, 8'd3); exp_f[1] = 32'hA; exp_f[2] = 32'hB; exp_f[3] = 32'hC;
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b0; exp_l[3] = 1'b1;
        clear_q();
        stall_bad = 0; ready_bad = 0;
        tog_idx = 0; toggle_mode = 1'b1;
        @(posedge clk); #1;
        send_pkt(5'd7, 3'd2, 8'd3, 32'hA);
        wait_idle();
        toggle_mode = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q_flit.size() != 4) begin errors++; $display("FAIL bp_count got %0d required 4", q_flit.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_flit[i] !== exp_f[i] || q_last[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL bp_flit%0d got %h/%b required %h/%b", i, q_flit[i], q_last[i], exp_f[i], exp_l[i]);
                end
            end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stall cycles required 0", stall_bad); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL bp_ready got %0d stalled cycles with ready high required 0", ready_bad); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_f[5];
        logic        exp_l[5];
        exp_f[0] = hexp(5'd1, 3'd0, 8'd1); exp_f[1] = 32'h100;
        exp_f[2] = hexp(5'd2, 3'd3, 8'd2); exp_f[3] = 32'h200; exp_f[4] = 32'h201;
        exp_l[0] = 1'b0; exp_l[1] = 1'b1; exp_l[2] = 1'b0; exp_l[3] = 1'b0; exp_l[4] = 1'b1;
        clear_q();
        send_pkt(5'd1, 3'd0, 8'd1, 32'h100);
        send_pkt(5'd2, 3'd3, 8'd2, 32'h200);
        wait_idle();
        checks++;
        if (q_flit.size() != 5) begin errors++; $display("FAIL b2b_count got %0d required 5", q_flit.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_flit[i] !== exp_f[i] || q_last[i] !== exp_l[i] || q_cyc[i] != q_cyc[0] + i) begin
                    errors++;
                    $display("FAIL b2b_flit%0d got %h/%b/cyc+%0d required %h/%b/cyc+%0d",
                             i, q_flit[i], q_last[i], q_cyc[i] - q_cyc[0], exp_f[i], exp_l[i], i);
                end
            end
        end
    endtask

    task automatic test_len255();
        int lasts;
        int bad_words;
        clear_q();
        send_pkt(5'd31, 3'd7, 8'd255, 32'h1000);
        wait_idle();
        checks++;
        if (q_flit.size() != 256) begin errors++; $display("FAIL len255_count got %0d required 256", q_flit.size()); end
        else begin
            lasts = 0; bad_words = 0;
            for (int i = 0; i < 256; i++) if (q_last[i] === 1'b1) lasts++;
            for (int i = 1; i < 256; i++) if (q_flit[i] !== 32'h1000 + 32'(i - 1)) bad_words++;
            checks++; if (q_flit[0] !== hexp(5'd31, 3'd7, 8'd255)) begin errors++; $display("FAIL len255_header got %h required %h", q_flit[0], hexp(5'd31, 3'd7, 8'd255)); end
            checks++; if (lasts != 1 || q_last[255] !== 1'b1) begin errors++; $display("FAIL len255_last got %0d lasts, final=%b required 1 lasts, final=1", lasts, q_last[255]); end
            checks++; if (bad_words != 0) begin errors++; $display("FAIL len255_payload got %0d bad words required 0", bad_words); end
            checks++; if (q_cyc[255] != q_cyc[0] + 255) begin errors++; $display("FAIL len255_rate got span %0d required 255", q_cyc[255] - q_cyc[0]); end
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_dest = 5'd4; req_class = 3'd2; req_len = 8'd5;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_req_ready got %b required 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0; in_valid = 1'b1; in_flit = 32'h50;
        @(posedge clk); #1;
        in_flit = 32'h51;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b required 0", out_valid); end
        checks++; if (busy !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rmid_state got busy=%b last=%b required 0/0", busy, out_last); end
        rst = 1'b0;
        @(posedge clk); #1;
        clear_q();
        send_pkt(5'd6, 3'd1, 8'd1, 32'h77);
        wait_idle();
        checks++;
        if (q_flit.size() != 2) begin errors++; $display("FAIL rmid_count got %0d required 2", q_flit.size()); end
        else begin
            checks++; if (q_flit[0] !== hexp(5'd6, 3'd1, 8'd1) || q_last[0] !== 1'b0) begin errors++; $display("FAIL rmid_header got %h/%b required %h/0", q_flit[0], q_last[0], hexp(5'd6, 3'd1, 8'd1)); end
            checks++; if (q_flit[1] !== 32'h77 || q_last[1] !== 1'b1) begin errors++; $display("FAIL rmid_payload got %h/%b required 00000077/1", q_flit[1], q_last[1]); end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; in_valid = 1'b0;
        req_dest = '0; req_class = '0; req_len = '0; in_flit = '0;
        @(posedge clk); #1;
        test_reset();
        test_len0();
        test_len3();
        test_backpressure();
        test_back_to_back();
        test_len255();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
